// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared pipeline types (shadow_ent_t), forward-select codes and GPR count
package core_pipe_pkg;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB = 2'd3;
  typedef struct packed {
    logic valid;
    logic we;
    logic [AW-1:0] dest;
    logic is_load;
  } shadow_ent_t;
endpackage

// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if: ID-stage hazard bus; master = ID stage (drives id_*, pipe_hold), slave = controller (drives stall/bubble/flush/fwd_sel, perf_* with HAZ_PERF_EN)
interface id_hazard_ctrl_if;
  import core_pipe_pkg::*;
  logic id_valid;
  logic [AW-1:0] id_raddr1;
  logic [AW-1:0] id_raddr2;
  logic id_re1;
  logic id_re2;
  logic id_rf_we;
  logic [AW-1:0] id_dest;
  logic id_is_load;
  logic id_br_taken;
  logic pipe_hold;
  logic id_stall;
  logic ex_bubble;
  logic if_flush;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif
  modport master (
    output id_valid, id_raddr1, id_raddr2, id_re1, id_re2, id_rf_we, id_dest, id_is_load, id_br_taken, pipe_hold,
    input id_stall, ex_bubble, if_flush, fwd_sel1, fwd_sel2
`ifdef HAZ_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );
  modport slave (
    input id_valid, id_raddr1, id_raddr2, id_re1, id_re2, id_rf_we, id_dest, id_is_load, id_br_taken, pipe_hold,
    output id_stall, ex_bubble, if_flush, fwd_sel1, fwd_sel2
`ifdef HAZ_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_src_match.sv
// hazard_src_match: per-source hit decode vs EX/MEM/WB shadow; in ex/mem/wb, re, raddr; out fwd_sel (youngest hit wins), load_hit
module hazard_src_match
  import core_pipe_pkg::*;
(
  input shadow_ent_t ex,
  input shadow_ent_t mem,
  input shadow_ent_t wb,
  input logic re,
  input logic [AW-1:0] raddr,
  output logic [1:0] fwd_sel,
  output logic load_hit
);
  logic hx, hm, hw, rd, unused_wb_ld;
  assign rd = re & (|raddr);
  assign hx = rd & ex.valid & ex.we & (ex.dest == raddr);
  assign hm = rd & mem.valid & mem.we & (mem.dest == raddr);
  assign hw = rd & wb.valid & wb.we & (wb.dest == raddr);
  assign fwd_sel = hx ? FWD_EX : hm ? FWD_MEM : hw ? FWD_WB : FWD_RF;
  assign load_hit = hx ? ex.is_load : hm & mem.is_load;
  assign unused_wb_ld = wb.is_load;
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID interlock/bypass controller; clk, resetn (async low), bus (slave: stall, bubble, flush, fwd_sel; perf counters with HAZ_PERF_EN)
module id_hazard_ctrl #(
  parameter int NREG = core_pipe_pkg::NREG,
  parameter int AW = $clog2(NREG)
) (
  input logic clk,
  input logic resetn,
  id_hazard_ctrl_if.slave bus
);
  import core_pipe_pkg::*;
  shadow_ent_t sh_ex, sh_mem, sh_wb;
  logic [1:0] s1, s2;
  logic lh1, lh2, lu;
  logic [AW-1:0] dest;
  assign dest = bus.id_dest;
  hazard_src_match m1 (.ex(sh_ex), .mem(sh_mem), .wb(sh_wb), .re(bus.id_re1), .raddr(bus.id_raddr1), .fwd_sel(s1), .load_hit(lh1));
  hazard_src_match m2 (.ex(sh_ex), .mem(sh_mem), .wb(sh_wb), .re(bus.id_re2), .raddr(bus.id_raddr2), .fwd_sel(s2), .load_hit(lh2));
  assign lu = lh1 | lh2;
  assign bus.id_stall = bus.pipe_hold | (bus.id_valid & lu);
  assign bus.ex_bubble = ~bus.pipe_hold & (~bus.id_valid | lu);
  assign bus.if_flush = bus.id_valid & bus.id_br_taken & ~bus.id_stall;
  assign bus.fwd_sel1 = bus.id_valid ? s1 : FWD_RF;
  assign bus.fwd_sel2 = bus.id_valid ? s2 : FWD_RF;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sh_ex <= '0;
      sh_mem <= '0;
      sh_wb <= '0;
    end else if (!bus.pipe_hold) begin
      sh_wb <= sh_mem;
      sh_mem <= sh_ex;
      sh_ex <= {~bus.ex_bubble, bus.id_rf_we, dest, bus.id_is_load};
    end
`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bus.perf_stall_cnt <= '0;
      bus.perf_flush_cnt <= '0;
    end else begin
      if (bus.id_valid & lu & ~bus.pipe_hold) bus.perf_stall_cnt <= bus.perf_stall_cnt + 32'd1;
      if (bus.if_flush) bus.perf_flush_cnt <= bus.perf_flush_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed self-checking bench for id_hazard_ctrl; obs = {stall, bubble, flush, sel1, sel2}
module tb_id_hazard_ctrl;
  logic clk = 0;
  logic resetn = 0;
  int checks = 0;
  int errors = 0;
  logic [6:0] obs;
  id_hazard_ctrl_if bus ();
  id_hazard_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  always #5 clk = ~clk;
  assign obs = {bus.id_stall, bus.ex_bubble, bus.if_flush, bus.fwd_sel1, bus.fwd_sel2};
  task automatic drv(input logic v, input logic [4:0] a1, input logic r1, input logic [4:0] a2, input logic r2,
                     input logic we, input logic [4:0] d, input logic ld, input logic br, input logic hold);
    bus.id_valid = v;
    bus.id_raddr1 = a1;
    bus.id_re1 = r1;
    bus.id_raddr2 = a2;
    bus.id_re2 = r2;
    bus.id_rf_we = we;
    bus.id_dest = d;
    bus.id_is_load = ld;
    bus.id_br_taken = br;
    bus.pipe_hold = hold;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask
  task automatic test_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (obs !== 7'b0100000) begin errors++; $display("FAIL reset_held got %b want %b", obs, 7'b0100000); end
    resetn = 1;
    step();
    checks++; if (obs !== 7'b0100000) begin errors++; $display("FAIL reset_release got %b want %b", obs, 7'b0100000); end
  endtask
  task automatic test_ex_fwd();
    idle();
    drv(1, 1, 1, 2, 1, 1, 5, 0, 0, 0);
    checks++; if (obs !== 7'b0000000) begin errors++; $display("FAIL fwd_nohit got %b want %b", obs, 7'b0000000); end
    step();
    drv(1, 5, 1, 5, 1, 1, 6, 0, 0, 0);
    checks++; if (obs !== 7'b0000101) begin errors++; $display("FAIL fwd_ex got %b want %b", obs, 7'b0000101); end
    step();
    drv(1, 5, 1, 0, 0, 1, 10, 0, 0, 0);
    checks++; if (obs !== 7'b0001000) begin errors++; $display("FAIL fwd_mem got %b want %b", obs, 7'b0001000); end
    step();
    drv(1, 5, 1, 0, 0, 1, 11, 0, 0, 0);
    checks++; if (obs !== 7'b0001100) begin errors++; $display("FAIL fwd_wb got %b want %b", obs, 7'b0001100); end
    step();
  endtask
  task automatic test_load_use();
    idle();
    drv(1, 1, 1, 0, 0, 1, 7, 1, 0, 0);
    step();
    drv(1, 7, 1, 0, 1, 1, 8, 0, 0, 0);
    checks++; if (obs !== 7'b1100100) begin errors++; $display("FAIL lu_ex got %b want %b", obs, 7'b1100100); end
    step();
    checks++; if (obs !== 7'b1101000) begin errors++; $display("FAIL lu_mem got %b want %b", obs, 7'b1101000); end
    step();
    checks++; if (obs !== 7'b0001100) begin errors++; $display("FAIL lu_wb got %b want %b", obs, 7'b0001100); end
    step();
  endtask
  task automatic test_priority();
    idle();
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step();
    drv(1, 3, 1, 0, 0, 1, 4, 0, 0, 0);
    checks++; if (obs !== 7'b1100100) begin errors++; $display("FAIL prio_ld_ex got %b want %b", obs, 7'b1100100); end
    step();
    checks++; if (obs !== 7'b1101000) begin errors++; $display("FAIL prio_ld_mem got %b want %b", obs, 7'b1101000); end
    step();
    checks++; if (obs !== 7'b0001100) begin errors++; $display("FAIL prio_ld_wb got %b want %b", obs, 7'b0001100); end
    step();
    idle();
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step();
    drv(1, 3, 1, 0, 0, 1, 4, 0, 0, 0);
    checks++; if (obs !== 7'b0000100) begin errors++; $display("FAIL prio_ex_over_ld got %b want %b", obs, 7'b0000100); end
    step();
  endtask
  task automatic test_branch();
`ifdef HAZ_PERF_EN
    logic [31:0] f0;
    f0 = bus.perf_flush_cnt;
`endif
    idle();
    drv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 20, 0, 0, 0);
    step();
    drv(1, 9, 1, 9, 1, 0, 0, 0, 1, 0);
    checks++; if (obs !== 7'b1101010) begin errors++; $display("FAIL br_stall got %b want %b", obs, 7'b1101010); end
    step();
    checks++; if (obs !== 7'b0011111) begin errors++; $display("FAIL br_flush got %b want %b", obs, 7'b0011111); end
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs !== 7'b0100000) begin errors++; $display("FAIL br_flush_once got %b want %b", obs, 7'b0100000); end
`ifdef HAZ_PERF_EN
    checks++; if (bus.perf_flush_cnt !== f0 + 32'd1) begin errors++; $display("FAIL perf_flush_br got %0d want %0d", bus.perf_flush_cnt, f0 + 32'd1); end
`endif
    idle();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step();
    drv(1, 0, 1, 0, 1, 1, 12, 0, 0, 0);
    checks++; if (obs !== 7'b0000000) begin errors++; $display("FAIL r0_nohit got %b want %b", obs, 7'b0000000); end
    step();
  endtask
  task automatic test_hold();
`ifdef HAZ_PERF_EN
    logic [31:0] s0, f0;
`endif
    idle();
    drv(1, 1, 1, 0, 0, 1, 7, 1, 0, 0);
    step();
`ifdef HAZ_PERF_EN
    s0 = bus.perf_stall_cnt;
`endif
    drv(1, 7, 1, 0, 0, 1, 8, 0, 0, 1);
    checks++; if (obs !== 7'b1000100) begin errors++; $display("FAIL hold_lu got %b want %b", obs, 7'b1000100); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (obs !== 7'b1000100) begin errors++; $display("FAIL hold_frozen%0d got %b want %b", i, obs, 7'b1000100); end
    end
    drv(1, 7, 1, 0, 0, 1, 8, 0, 0, 0);
    checks++; if (obs !== 7'b1100100) begin errors++; $display("FAIL hold_rel_ex got %b want %b", obs, 7'b1100100); end
    step();
    checks++; if (obs !== 7'b1101000) begin errors++; $display("FAIL hold_rel_mem got %b want %b", obs, 7'b1101000); end
    step();
    checks++; if (obs !== 7'b0001100) begin errors++; $display("FAIL hold_rel_wb got %b want %b", obs, 7'b0001100); end
`ifdef HAZ_PERF_EN
    checks++; if (bus.perf_stall_cnt !== s0 + 32'd2) begin errors++; $display("FAIL perf_stall got %0d want %0d", bus.perf_stall_cnt, s0 + 32'd2); end
    f0 = bus.perf_flush_cnt;
`endif
    step();
    drv(1, 1, 1, 1, 1, 0, 0, 0, 1, 1);
    checks++; if (obs !== 7'b1000000) begin errors++; $display("FAIL hold_br got %b want %b", obs, 7'b1000000); end
    step();
    drv(1, 1, 1, 1, 1, 0, 0, 0, 1, 0);
    checks++; if (obs !== 7'b0010000) begin errors++; $display("FAIL hold_br_rel got %b want %b", obs, 7'b0010000); end
    step();
`ifdef HAZ_PERF_EN
    checks++; if (bus.perf_flush_cnt !== f0 + 32'd1) begin errors++; $display("FAIL perf_flush_hold got %0d want %0d", bus.perf_flush_cnt, f0 + 32'd1); end
`endif
  endtask
  task automatic test_reset_mid();
    idle();
    drv(1, 1, 1, 0, 0, 1, 7, 1, 0, 0);
    step();
    drv(1, 7, 1, 0, 0, 1, 8, 0, 0, 0);
    checks++; if (obs !== 7'b1100100) begin errors++; $display("FAIL rmid_stall got %b want %b", obs, 7'b1100100); end
    resetn = 0;
    #1;
    checks++; if (obs !== 7'b0000000) begin errors++; $display("FAIL rmid_async got %b want %b", obs, 7'b0000000); end
    step();
    @(negedge clk);
    resetn = 1;
    #1;
    checks++; if (obs !== 7'b0000000) begin errors++; $display("FAIL rmid_release got %b want %b", obs, 7'b0000000); end
    step();
  endtask
  initial begin
    test_reset();
    test_ex_fwd();
    test_load_use();
    test_priority();
    test_branch();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
